// File: rtl/spi_slave.sv
// SPI target endpoint: oversampled sclk/ss/mosi, cfg/tx loaded over req/ack; rx words out as a one-cycle pulse, no backpressure.
// Pin edge to internal action is SYNC_STAGES+1 clk. Optional SPI_SLAVE_TX_UNDERRUN_EN adds a sticky tx_underrun flag.
module spi_slave #(
    parameter int DATA_WIDTH = 8,
    parameter int SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] TX_IDLE = 8'hFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] address,
    output logic                  ack,
    input  logic                  sclk,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  busy
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
    ,
    output logic                  tx_underrun
`endif
);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state;

    logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic                   sclk_s, ss_s, mosi_s, sclk_prev, ss_prev;
    logic [2:0]             cfg, cfg_act;
    logic [DATA_WIDTH-1:0]  tx_buf, tx_shift, tx_nxt, rx_shift, rx_nxt, word_load;
    logic                   tx_pending, skip;
    logic [CW-1:0]          bit_cnt;
    logic                   dir, cpol, cpha, lead, trail, sample_edge, shift_edge;
    logic                   ss_rise, ss_fall, wr_en, word_done, word_start;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign ss_s   = ss_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];

    assign dir  = cfg_act[0];
    assign cpol = cfg_act[1];
    assign cpha = cfg_act[2];

    assign lead        = (sclk_prev == cpol) && (sclk_s != cpol);
    assign trail       = (sclk_prev != cpol) && (sclk_s == cpol);
    assign sample_edge = (state == ACTIVE) && (cpha ? trail : lead);
    assign shift_edge  = (state == ACTIVE) && (cpha ? lead : trail);
    assign ss_rise     = ss_s & ~ss_prev;
    assign ss_fall     = ~ss_s & ss_prev;
    assign wr_en       = req & ~ack;

    assign word_load  = tx_pending ? tx_buf : TX_IDLE;
    assign rx_nxt     = dir ? {rx_shift[DATA_WIDTH-2:0], mosi_s} : {mosi_s, rx_shift[DATA_WIDTH-1:1]};
    assign word_done  = sample_edge && (bit_cnt == CW'(DATA_WIDTH - 1));
    assign word_start = ((state == IDLE) && ss_rise) || ((state == ACTIVE) && !ss_fall && word_done);

    // After any reload the first shift edge is consumed: the new word's first bit is already on miso.
    always_comb begin
        tx_nxt = tx_shift;
        if (word_start)
            tx_nxt = word_load;
        else if (shift_edge && !skip)
            tx_nxt = dir ? {tx_shift[DATA_WIDTH-2:0], 1'b0} : {1'b0, tx_shift[DATA_WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            sclk_sync  <= '0;
            ss_sync    <= '0;
            mosi_sync  <= '0;
            sclk_prev  <= 1'b0;
            ss_prev    <= 1'b0;
            ack        <= 1'b0;
            miso       <= 1'b0;
            rx_valid   <= 1'b0;
            busy       <= 1'b0;
            rx_data    <= '0;
            cfg        <= '0;
            cfg_act    <= '0;
            tx_buf     <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            tx_pending <= 1'b0;
            skip       <= 1'b0;
            bit_cnt    <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_s;
            ss_prev   <= ss_s;
            ack       <= req & ~ack;
            rx_valid  <= 1'b0;
            tx_shift  <= tx_nxt;

            if (wr_en && address == DATA_WIDTH'(0))
                cfg <= data_in[2:0];
            if (wr_en && address == DATA_WIDTH'(1))
                tx_buf <= data_in;
            if (wr_en && address == DATA_WIDTH'(1))
                tx_pending <= 1'b1;
            else if (word_start)
                tx_pending <= 1'b0;

            case (state)
                IDLE: begin
                    miso <= 1'b0;
                    busy <= 1'b0;
                    if (ss_rise) begin
                        state   <= ACTIVE;
                        cfg_act <= cfg;
                        bit_cnt <= '0;
                        skip    <= cfg[2];
                        busy    <= 1'b1;
                        miso    <= cfg[0] ? tx_nxt[DATA_WIDTH-1] : tx_nxt[0];
                    end
                end
                ACTIVE: begin
                    if (ss_fall) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        miso  <= 1'b0;
                    end else begin
                        miso <= dir ? tx_nxt[DATA_WIDTH-1] : tx_nxt[0];
                        if (sample_edge) begin
                            rx_shift <= rx_nxt;
                            if (word_done) begin
                                rx_data  <= rx_nxt;
                                rx_valid <= 1'b1;
                                bit_cnt  <= '0;
                                skip     <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else if (shift_edge) begin
                            skip <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_SLAVE_TX_UNDERRUN_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            tx_underrun <= 1'b0;
        else if (word_start && !tx_pending)
            tx_underrun <= 1'b1;
        else if (wr_en && address == DATA_WIDTH'(2))
            tx_underrun <= 1'b0;
    end
`endif
endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: acts as SPI master and register writer, checks rx words and returned miso words.
module tb_spi_slave;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] address = '0;
    logic       ack;
    logic       sclk = 1'b0;
    logic       ss = 1'b0;
    logic       mosi = 1'b0;
    logic       miso;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       busy;
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
    logic       tx_underrun;
`endif

    int n_pass = 0;
    int n_total = 0;
    int rx_cnt = 0;
    logic [7:0] rx_last = '0;

    localparam int H = 8;   // sclk half-period in clk cycles

    spi_slave dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .address(address), .ack(ack),
        .sclk(sclk), .ss(ss), .mosi(mosi), .miso(miso),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy)
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
        , .tx_underrun(tx_underrun)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) begin
            rx_cnt  = rx_cnt + 1;
            rx_last = rx_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
        int n;
        @(negedge clk);
        req = 1'b1; address = a; data_in = d;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!ack && n < 8);
        chk("reg_write ack", ack, 1);
        req = 1'b0;
        wait_clk(2);
    endtask

    task automatic ss_start(input bit cpol);
        sclk = cpol;
        wait_clk(H);
        ss = 1'b1;
        wait_clk(H);
    endtask

    task automatic ss_end();
        wait_clk(H);
        ss = 1'b0;
        wait_clk(H);
    endtask

    // Master side of one word; got collects miso into the same bit order as the word itself.
    task automatic xfer(input bit cpol, input bit cpha, input bit dir, input logic [7:0] word,
                        input int nbits, output logic [7:0] got);
        int idx;
        got = '0;
        for (int i = 0; i < nbits; i++) begin
            idx = dir ? 7 - i : i;
            if (!cpha) begin
                mosi = word[idx];
                wait_clk(H);
                got[idx] = miso;
                sclk = ~cpol;
                wait_clk(H);
                sclk = cpol;
            end else begin
                sclk = ~cpol;
                mosi = word[idx];
                wait_clk(H);
                got[idx] = miso;
                sclk = cpol;
                wait_clk(H);
            end
        end
        wait_clk(H);
    endtask

    logic [7:0] got;
    int         cnt0;

    initial begin
        // Reset
        wait_clk(4);
        chk("reset ack", ack, 0);
        chk("reset miso", miso, 0);
        chk("reset rx_valid", rx_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset rx_data", rx_data, 8'h00);
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
        chk("reset tx_underrun", tx_underrun, 0);
`endif
        rst_n = 1'b1;
        wait_clk(2);

        // Held req on an ignored address: ack toggles every other cycle
        req = 1'b1; address = 8'd3; data_in = 8'h55;
        @(negedge clk); chk("b2b ack c1", ack, 1);
        @(negedge clk); chk("b2b ack c2", ack, 0);
        @(negedge clk); chk("b2b ack c3", ack, 1);
        @(negedge clk); chk("b2b ack c4", ack, 0);
        req = 1'b0;
        wait_clk(2);

        // Mode 0, MSB-first
        reg_write(8'd0, 8'h01);
        reg_write(8'd1, 8'hA5);
        cnt0 = rx_cnt;
        ss_start(1'b0);
        chk("m0 busy", busy, 1);
        chk("m0 first miso", miso, 1);
        xfer(1'b0, 1'b0, 1'b1, 8'h3C, 8, got);
        chk("m0 miso word", got, 8'hA5);
        chk("m0 rx count", rx_cnt - cnt0, 1);
        chk("m0 rx data", rx_last, 8'h3C);
        ss_end();
        chk("m0 busy low", busy, 0);
        chk("m0 miso low", miso, 0);

        // CPOL 1, CPHA 1, MSB-first
        reg_write(8'd0, 8'h07);
        reg_write(8'd1, 8'hA5);
        cnt0 = rx_cnt;
        ss_start(1'b1);
        xfer(1'b1, 1'b1, 1'b1, 8'h3C, 8, got);
        chk("m3 miso word", got, 8'hA5);
        chk("m3 rx count", rx_cnt - cnt0, 1);
        chk("m3 rx data", rx_last, 8'h3C);
        ss_end();

        // Mode 0, LSB-first
        reg_write(8'd0, 8'h00);
        reg_write(8'd1, 8'hA5);
        cnt0 = rx_cnt;
        ss_start(1'b0);
        chk("lsb first miso", miso, 1);
        xfer(1'b0, 1'b0, 1'b0, 8'h3C, 8, got);
        chk("lsb miso word", got, 8'hA5);
        chk("lsb rx count", rx_cnt - cnt0, 1);
        chk("lsb rx data", rx_last, 8'h3C);
        ss_end();

        // No tx data pending: idle word goes out
        reg_write(8'd0, 8'h01);
        reg_write(8'd2, 8'h00);
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
        chk("underrun cleared", tx_underrun, 0);
`endif
        cnt0 = rx_cnt;
        ss_start(1'b0);
`ifdef SPI_SLAVE_TX_UNDERRUN_EN
        chk("underrun set", tx_underrun, 1);
        reg_write(8'd2, 8'h00);
        chk("underrun clear by addr2", tx_underrun, 0);
`endif
        xfer(1'b0, 1'b0, 1'b1, 8'hC6, 8, got);
        chk("idle miso word", got, 8'hFF);
        chk("idle rx data", rx_last, 8'hC6);
        ss_end();

        // Three back-to-back words with tx refilled during each word
        reg_write(8'd1, 8'h81);
        cnt0 = rx_cnt;
        ss_start(1'b0);
        reg_write(8'd1, 8'hC3);
        xfer(1'b0, 1'b0, 1'b1, 8'h11, 8, got);
        chk("b2b w1 miso", got, 8'h81);
        chk("b2b w1 rx", rx_last, 8'h11);
        reg_write(8'd1, 8'h7E);
        xfer(1'b0, 1'b0, 1'b1, 8'h22, 8, got);
        chk("b2b w2 miso", got, 8'hC3);
        chk("b2b w2 rx", rx_last, 8'h22);
        xfer(1'b0, 1'b0, 1'b1, 8'h33, 8, got);
        chk("b2b w3 miso", got, 8'h7E);
        chk("b2b w3 rx", rx_last, 8'h33);
        chk("b2b rx count", rx_cnt - cnt0, 3);
        ss_end();

        // Abort after 5 bits, then a clean word
        cnt0 = rx_cnt;
        ss_start(1'b0);
        xfer(1'b0, 1'b0, 1'b1, 8'hF0, 5, got);
        ss_end();
        chk("abort rx count", rx_cnt - cnt0, 0);
        chk("abort busy", busy, 0);
        reg_write(8'd1, 8'h96);
        ss_start(1'b0);
        xfer(1'b0, 1'b0, 1'b1, 8'h5A, 8, got);
        chk("post-abort rx count", rx_cnt - cnt0, 1);
        chk("post-abort rx data", rx_last, 8'h5A);
        chk("post-abort miso", got, 8'h96);
        ss_end();

        // cfg write mid-transfer only applies from the next ss assertion
        reg_write(8'd1, 8'h3C);
        ss_start(1'b0);
        reg_write(8'd0, 8'h02);
        xfer(1'b0, 1'b0, 1'b1, 8'h3C, 8, got);
        chk("old mode rx", rx_last, 8'h3C);
        chk("old mode miso", got, 8'h3C);
        ss_end();
        reg_write(8'd1, 8'hA5);
        cnt0 = rx_cnt;
        ss_start(1'b1);
        xfer(1'b1, 1'b0, 1'b0, 8'h5A, 8, got);
        chk("new mode rx count", rx_cnt - cnt0, 1);
        chk("new mode rx", rx_last, 8'h5A);
        chk("new mode miso", got, 8'hA5);
        ss_end();

        // Reset mid-word aborts without rx_valid
        cnt0 = rx_cnt;
        ss_start(1'b1);
        xfer(1'b1, 1'b0, 1'b0, 8'h77, 4, got);
        rst_n = 1'b0;
        wait_clk(2);
        chk("mid reset busy", busy, 0);
        chk("mid reset rx_data", rx_data, 8'h00);
        chk("mid reset rx count", rx_cnt - cnt0, 0);
        ss = 1'b0;
        rst_n = 1'b1;
        wait_clk(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
- SPI target-side endpoint: receives serial words from an SPI master and returns a serial word on miso during each transfer.
- Oversamples sclk/ss/mosi in the system clock domain; CPOL, CPHA and bit order come from an on-block config register.
- Configured and loaded through the same req/ack/address register interface the team's master uses.
- Received words leave on a parallel rx_data/rx_valid port.

Parameters:
DATA_WIDTH, 8, word width and register data width
SYNC_STAGES, 2, synchronizer depth on sclk, ss, mosi (min 2)
TX_IDLE, 8'hFF, word shifted out when no tx data is pending

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous reset, active low
req  input  1  register write request
data_in  input  DATA_WIDTH  register write data
address  input  DATA_WIDTH  0 = config {len unused[7:3], CPHA[2], CPOL[1], dir[0]}, 1 = tx data, others ignored
ack  output  1  one-cycle acknowledge of req
sclk  input  1  serial clock from master
ss  input  1  slave select, active high
mosi  input  1  serial data from master
miso  output  1  serial data to master
rx_data  output  DATA_WIDTH  last completed received word
rx_valid  output  1  one-cycle pulse, rx_data updated
busy  output  1  high while a transfer is active

Behaviour:
- Reset (rst_n low at posedge clk): ack, miso, rx_valid, busy = 0; rx_data, cfg, tx_buf = 0; tx_pending = 0; FSM = IDLE. Reset mid-transfer aborts without rx_valid.
- Register interface:
  - ack <= req & ~ack.
  - Write takes effect on the cycle ack = 1.
  - address 0 writes cfg.
  - address 1 writes tx_buf and sets tx_pending.
  - Back-to-back req gives ack every other cycle.
- Input handling: sclk, ss, mosi pass through SYNC_STAGES flops. Edges are detected on synced sclk versus its previous value.
- Edge definitions:
  - Leading edge = synced sclk leaves the CPOL level. Trailing edge = returns to it.
  - Sample edge = leading if CPHA = 0, trailing if CPHA = 1. Shift edge = the other one.
- Latency: sclk pin edge to internal action = SYNC_STAGES+1 clk. The master's sclk half-period must be >= 4 clk.
- FSM IDLE -> ACTIVE on synced ss rising:
  - Latch active cfg copy.
  - Load tx_shift = tx_pending ? tx_buf : TX_IDLE; clear tx_pending; bit_cnt = 0; busy = 1.
- ACTIVE:
  - miso = dir ? tx_shift[MSB] : tx_shift[0].
  - Sample edge: rx_shift shifts in synced mosi. dir = 1 shifts left inserting at bit 0; dir = 0 shifts right inserting at MSB. bit_cnt++.
  - Shift edge: tx_shift shifts (dir = 1 left, dir = 0 right). Exception: with CPHA = 1 the first shift edge of each word does not shift.
  - When bit_cnt reaches DATA_WIDTH on a sample edge, the next cycle gives rx_data = assembled word, rx_valid = 1 for one cycle, bit_cnt = 0.
  - If ss is still high after a completed word, reload tx_shift as at word start (back-to-back words).
- ACTIVE -> IDLE on synced ss falling:
  - A partial word is discarded with no rx_valid.
  - busy = 0, miso = 0.
- Config and tx writes while busy:
  - cfg write takes effect at the next IDLE -> ACTIVE.
  - tx write while busy is buffered and used at the next word start. A second write before that overwrites it.
- sclk edges while ss is low are ignored. rx_valid has no backpressure.

Optional Feature:
- Macro SPI_SLAVE_TX_UNDERRUN_EN.
- When defined, adds output tx_underrun (1 bit, reset 0).
  - Sticky set when a word starts with tx_pending = 0, i.e. TX_IDLE is sent.
  - Cleared by a register write to address 2; that write is acked and has no other effect.
  - Set and clear in the same cycle: set wins.
- When undefined, the port and logic are absent, and an address 2 write is acked and ignored.

Test Plan:
- Reset: write cfg 0x01, tx 0xA5; master sends 0x3C, CPOL 0, CPHA 0, MSB-first -> rx_valid one pulse with rx_data 0x3C; miso bits 1,0,1,0,0,1,0,1.
- Modes: repeat the exchange with cfg 0x07 (CPOL 1, CPHA 1, MSB-first) and cfg 0x00 (LSB-first) -> rx 0x3C and miso 0xA5 in the correct order each time.
- No tx write before transfer -> miso returns 0xFF; with SPI_SLAVE_TX_UNDERRUN_EN, tx_underrun = 1 until an address-2 write clears it.
- ss held high for 3 words 0x11, 0x22, 0x33 with tx written between words -> three rx_valid pulses in order; each miso word matches its preload.
- ss drops after 5 bits -> no rx_valid; busy = 0; next full word 0x5A is received correctly.
- cfg write to 0x02 during an active word -> current word still uses the old mode; next word samples with CPOL 1.
